axi_sram_slave: RTL and testbench

- AXI4 slave that terminates the CPU top's AXI master port (ar/r/aw/w/b channels) onto a single-port, word-wide synchronous SRAM.
- Sits directly downstream of the core wrapper in SoC and simulation builds.
- Serves one transaction at a time. Reads and writes share the SRAM port and alternate fairly.
- Supports FIXED/INCR/WRAP bursts up to 256 beats.

---
 rtl/axi_sram_slave_if.sv | 71 +++++++
 rtl/axi_sram_slave.sv | 252 +++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between the CPU top's master port and axi_sram_slave.
// Carries the five AXI channels (ar, r, aw, w, b) and their valid/ready pairs.
// Modports:
//   master - drives ar/aw/w payloads and valids, rready, bready
//   slave  - drives arready, awready, wready, r and b payloads and valids
// Handshake rule for every channel: a beat transfers on a rising clock edge
// where valid and ready are both high; payload is meaningful only while valid
// is high, and the sender holds payload stable until that edge.
interface axi_sram_slave_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave terminating one AXI master onto a single-port, word-wide
// synchronous SRAM. One transaction at a time; reads and writes alternate
// when both are requested. FIXED/INCR/WRAP bursts up to 256 beats.
//
// Optional feature macro: AXI_SRAM_SLAVE_WRAP_EN
//   defined   - WRAP bursts wrap at (len+1)*(1<<size) bytes
//   undefined - WRAP behaves as INCR and is answered with SLVERR (like 2'b11)
//
// Ports:
//   aclk, aresetn  - clock, asynchronous active-low reset
//   axi            - AXI4 slave modport (ar/r/aw/w/b channels)
//   sram_en        - SRAM access enable (one access per cycle)
//   sram_we        - per-byte write enable (0 = read)
//   sram_addr      - SRAM word address (byte address bits [ADDR_W+1:2])
//   sram_wdata     - SRAM write data
//   sram_rdata     - SRAM read data, valid the cycle after a read enable,
//                    held until the next enable
//   dbg_state      - current FSM state (0 IDLE, 1 RD, 2 WR, 3 BRESP)
module axi_sram_slave #(
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_sram_slave_if.slave   axi,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
`ifdef AXI_SRAM_SLAVE_WRAP_EN
  localparam logic [1:0] BURST_WRAP  = 2'b10;
`endif
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD    = 2'd1,
    S_WR    = 2'd2,
    S_BRESP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] id_q;
  logic [31:0]     addr_q;      // current byte address of the burst
  logic [7:0]      len_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [7:0]      beat_q;
  logic            err_q;       // write burst error, reported in bresp
  logic            lg_write_q;  // last grant was a write

  logic            rd_pick;
  logic            wr_pick;
  logic            last_beat;
  logic [31:0]     step;
  logic [31:0]     adv_addr;
`ifdef AXI_SRAM_SLAVE_WRAP_EN
  logic [31:0]     wrap_mask;
`endif

  // Burst types answered with SLVERR. Without wrap support, WRAP joins the
  // reserved encoding as an error.
  function automatic logic burst_err(input logic [1:0] b);
`ifdef AXI_SRAM_SLAVE_WRAP_EN
    return (b == 2'b11);
`else
    return (b == 2'b11) | (b == 2'b10);
`endif
  endfunction

  // Fair arbitration: on a tie, serve the channel not served last time.
  assign rd_pick   = axi.arvalid & (~axi.awvalid | lg_write_q);
  assign wr_pick   = axi.awvalid & ~rd_pick;
  assign last_beat = (beat_q == len_q);
  assign dbg_state = state_q;

  // Next byte address within the burst.
  always_comb begin
    step     = 32'd1 << size_q;
    adv_addr = addr_q + step;
`ifdef AXI_SRAM_SLAVE_WRAP_EN
    // Wrap boundary is (len+1)*step bytes; legal WRAP lengths make it a
    // power of two, so the wrap is a mask on the low address bits.
    wrap_mask = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
`endif
    if (burst_q == BURST_FIXED) begin
      adv_addr = addr_q;
    end
`ifdef AXI_SRAM_SLAVE_WRAP_EN
    else if (burst_q == BURST_WRAP) begin
      adv_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
    end
`endif
  end

  // Next state and all outputs.
  always_comb begin
    state_d     = state_q;
    axi.arready = 1'b0;
    axi.awready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = 32'd0;
    axi.rid     = '0;
    axi.rlast   = 1'b0;
    axi.rresp   = RESP_OKAY;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bid     = '0;
    axi.bresp   = RESP_OKAY;
    sram_en     = 1'b0;
    sram_we     = 4'd0;
    sram_addr   = '0;
    sram_wdata  = 32'd0;

    case (state_q)
      S_IDLE: begin
        axi.arready = rd_pick;
        axi.awready = wr_pick;
        if (rd_pick) begin
          // First read is issued on the AR handshake so data is ready in RD.
          sram_en   = 1'b1;
          sram_addr = axi.araddr[ADDR_W+1:2];
          state_d   = S_RD;
        end else if (wr_pick) begin
          state_d = S_WR;
        end
      end

      S_RD: begin
        axi.rvalid = 1'b1;
        axi.rdata  = sram_rdata;
        axi.rid    = id_q;
        axi.rlast  = last_beat;
        axi.rresp  = burst_err(burst_q) ? RESP_SLVERR : RESP_OKAY;
        if (axi.rready) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            // Prefetch the next beat; SRAM holds rdata while stalled.
            sram_en   = 1'b1;
            sram_addr = adv_addr[ADDR_W+1:2];
          end
        end
      end

      S_WR: begin
        axi.wready = 1'b1;
        if (axi.wvalid) begin
          sram_en    = 1'b1;
          sram_we    = axi.wstrb;
          sram_wdata = axi.wdata;
          sram_addr  = addr_q[ADDR_W+1:2];
          // Burst length comes from awlen; wlast is only checked.
          if (last_beat) begin
            state_d = S_BRESP;
          end
        end
      end

      S_BRESP: begin
        axi.bvalid = 1'b1;
        axi.bid    = id_q;
        axi.bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (axi.bready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst context registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      id_q       <= '0;
      addr_q     <= 32'd0;
      len_q      <= 8'd0;
      size_q     <= 3'd0;
      burst_q    <= 2'd0;
      beat_q     <= 8'd0;
      err_q      <= 1'b0;
      lg_write_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rd_pick) begin
            id_q    <= axi.arid;
            addr_q  <= axi.araddr;
            len_q   <= axi.arlen;
            size_q  <= axi.arsize;
            burst_q <= axi.arburst;
            beat_q  <= 8'd0;
            err_q   <= 1'b0;
          end else if (wr_pick) begin
            id_q    <= axi.awid;
            addr_q  <= axi.awaddr;
            len_q   <= axi.awlen;
            size_q  <= axi.awsize;
            burst_q <= axi.awburst;
            beat_q  <= 8'd0;
            err_q   <= burst_err(axi.awburst);
          end
        end

        S_RD: begin
          if (axi.rready) begin
            if (last_beat) begin
              lg_write_q <= 1'b0;
            end else begin
              addr_q <= adv_addr;
              beat_q <= beat_q + 8'd1;
            end
          end
        end

        S_WR: begin
          if (axi.wvalid) begin
            addr_q <= adv_addr;
            beat_q <= beat_q + 8'd1;
            if (axi.wlast != last_beat) begin
              err_q <= 1'b1;
            end
          end
        end

        S_BRESP: begin
          if (axi.bready) begin
            lg_write_q <= 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

  localparam int ADDR_W = 16;
  localparam int ID_W   = 4;

  logic              aclk;
  logic              aresetn;
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic [1:0]        dbg_state;

  axi_sram_slave_if #(.ID_W(ID_W)) ifc ();

  axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .axi        (ifc),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [15:0] wr_addr_q[$];
  logic [3:0]  wr_we_q[$];
  logic [15:0] exp_addr_q[$];
  int          en_count = 0;

  logic [31:0] mem [0:65535];
  logic [31:0] merge_w;

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- SRAM model ----------------
  always @(posedge aclk) begin
    if (sram_en) begin
      en_count = en_count + 1;
      if (sram_we == 4'd0) begin
        sram_rdata = mem[sram_addr];
      end else begin
        merge_w = mem[sram_addr];
        for (int b = 0; b < 4; b++) begin
          if (sram_we[b]) merge_w[8*b +: 8] = sram_wdata[8*b +: 8];
        end
        mem[sram_addr] = merge_w;
        wr_addr_q.push_back(sram_addr);
        wr_we_q.push_back(sram_we);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    @(negedge aclk);
    ifc.awid = id; ifc.awaddr = addr; ifc.awlen = len;
    ifc.awsize = 3'd2; ifc.awburst = burst; ifc.awvalid = 1'b1;
    #1;
    n = 0;
    while (ifc.awready !== 1'b1 && n < 20) begin
      @(negedge aclk); #1; n++;
    end
    total++;
    if (ifc.awready !== 1'b1) begin
      bad++; $display("FAIL aw_timeout got awready=%b want 1", ifc.awready);
    end
    @(posedge aclk); #1;
    ifc.awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    @(negedge aclk);
    ifc.arid = id; ifc.araddr = addr; ifc.arlen = len;
    ifc.arsize = 3'd2; ifc.arburst = burst; ifc.arvalid = 1'b1;
    #1;
    n = 0;
    while (ifc.arready !== 1'b1 && n < 20) begin
      @(negedge aclk); #1; n++;
    end
    total++;
    if (ifc.arready !== 1'b1) begin
      bad++; $display("FAIL ar_timeout got arready=%b want 1", ifc.arready);
    end
    @(posedge aclk); #1;
    ifc.arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n;
    @(negedge aclk);
    ifc.wdata = data; ifc.wstrb = strb; ifc.wlast = last; ifc.wvalid = 1'b1;
    #1;
    n = 0;
    while (ifc.wready !== 1'b1 && n < 20) begin
      @(negedge aclk); #1; n++;
    end
    total++;
    if (ifc.wready !== 1'b1) begin
      bad++; $display("FAIL w_timeout got wready=%b want 1", ifc.wready);
    end
    @(posedge aclk); #1;
    ifc.wvalid = 1'b0;
  endtask

  task automatic recv_b(output logic [1:0] resp, output logic [3:0] id);
    int n;
    @(negedge aclk);
    ifc.bready = 1'b1;
    #1;
    n = 0;
    while (ifc.bvalid !== 1'b1 && n < 20) begin
      @(negedge aclk); #1; n++;
    end
    total++;
    if (ifc.bvalid !== 1'b1) begin
      bad++; $display("FAIL b_timeout got bvalid=%b want 1", ifc.bvalid);
    end
    resp = ifc.bresp; id = ifc.bid;
    @(posedge aclk); #1;
    ifc.bready = 1'b0;
  endtask

  task automatic recv_r(output logic [31:0] data, output logic last,
                        output logic [1:0] resp, output logic [3:0] id);
    int n;
    @(negedge aclk);
    ifc.rready = 1'b1;
    #1;
    n = 0;
    while (ifc.rvalid !== 1'b1 && n < 20) begin
      @(negedge aclk); #1; n++;
    end
    total++;
    if (ifc.rvalid !== 1'b1) begin
      bad++; $display("FAIL r_timeout got rvalid=%b want 1", ifc.rvalid);
    end
    data = ifc.rdata; last = ifc.rlast; resp = ifc.rresp; id = ifc.rid;
    @(posedge aclk); #1;
    ifc.rready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] outs;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    outs = {ifc.arready, ifc.awready, ifc.rvalid, ifc.wready, ifc.bvalid,
            ifc.rlast, ifc.rresp, ifc.bresp, ifc.rid, ifc.bid, sram_en, sram_we, dbg_state};
    total++;
    if (outs !== 32'd0) begin
      bad++; $display("FAIL reset_ctrl got %h want 0", outs);
    end
    total++;
    if ({ifc.rdata, sram_wdata, sram_addr} !== 80'd0) begin
      bad++; $display("FAIL reset_data got %h/%h/%h want 0", ifc.rdata, sram_wdata, sram_addr);
    end
    aresetn = 1'b1;
    @(negedge aclk); #1;
    total++;
    if ({sram_en, ifc.rvalid, ifc.bvalid, ifc.wready, dbg_state} !== 6'd0) begin
      bad++; $display("FAIL idle_after_reset got en=%b rv=%b bv=%b wr=%b st=%0d want 0",
                      sram_en, ifc.rvalid, ifc.bvalid, ifc.wready, dbg_state);
    end
  endtask

  task automatic test_single();
    logic [1:0] resp; logic [3:0] id; logic [31:0] data; logic last; logic [31:0] e;
    send_aw(4'd1, 32'h100, 8'd0, 2'b01);
    send_w(32'hDEADBEEF, 4'hF, 1'b1);
    recv_b(resp, id);
    total++;
    if (resp !== 2'b00 || id !== 4'd1) begin
      bad++; $display("FAIL single_bresp got resp=%b id=%0d want 00/1", resp, id);
    end
    total++;
    if (mem[16'h40] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_sram got %h want deadbeef", mem[16'h40]);
    end
    exp_q.push_back(32'hDEADBEEF);
    send_ar(4'd9, 32'h100, 8'd0, 2'b01);
    recv_r(data, last, resp, id);
    e = exp_q.pop_front();
    total++;
    if (data !== e || last !== 1'b1 || resp !== 2'b00 || id !== 4'd9) begin
      bad++; $display("FAIL single_read got %h last=%b resp=%b id=%0d want %h 1 00 9",
                      data, last, resp, id, e);
    end
  endtask

  task automatic test_incr_backpressure();
    bit pat [0:5];
    int beats, base;
    logic [31:0] e;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      mem[16'h80 + i] = 32'(i + 1);
      exp_q.push_back(32'(i + 1));
    end
    base = en_count;
    send_ar(4'd3, 32'h200, 8'd3, 2'b01);
    beats = 0;
    for (int cyc = 0; cyc < 30 && beats < 4; cyc++) begin
      @(negedge aclk);
      ifc.rready = (cyc < 6) ? pat[cyc] : 1'b1;
      #1;
      total++;
      if (ifc.rvalid !== 1'b1 || ifc.rlast !== (beats == 3)) begin
        bad++; $display("FAIL incr_rvalid_rlast beat %0d got rv=%b rl=%b want 1/%b",
                        beats, ifc.rvalid, ifc.rlast, beats == 3);
      end
      if (ifc.rready) begin
        e = exp_q.pop_front();
        total++;
        if (ifc.rdata !== e || ifc.rresp !== 2'b00 || sram_en !== (beats < 3)) begin
          bad++; $display("FAIL incr_beat %0d got %h resp=%b en=%b want %h 00 %b",
                          beats, ifc.rdata, ifc.rresp, sram_en, e, beats < 3);
        end
        beats++;
      end else begin
        total++;
        if (ifc.rdata !== exp_q[0] || sram_en !== 1'b0) begin
          bad++; $display("FAIL incr_stall got %h en=%b want %h en=0", ifc.rdata, sram_en, exp_q[0]);
        end
      end
      @(posedge aclk);
    end
    #1;
    ifc.rready = 1'b0;
    total++;
    if (beats != 4 || en_count - base != 4) begin
      bad++; $display("FAIL incr_count got beats=%0d en=%0d want 4/4", beats, en_count - base);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] resp, exp_resp; logic [3:0] id;
    logic [15:0] a; logic [3:0] we;
    wr_addr_q.delete(); wr_we_q.delete(); exp_addr_q.delete();
`ifdef AXI_SRAM_SLAVE_WRAP_EN
    exp_addr_q = '{16'h0E, 16'h0F, 16'h0C, 16'h0D};
    exp_resp = 2'b00;
`else
    exp_addr_q = '{16'h0E, 16'h0F, 16'h10, 16'h11};
    exp_resp = 2'b10;
`endif
    send_aw(4'd7, 32'h38, 8'd3, 2'b10);
    for (int i = 0; i < 4; i++) send_w(32'hA0 + 32'(i), 4'hF, i == 3);
    recv_b(resp, id);
    total++;
    if (resp !== exp_resp || id !== 4'd7) begin
      bad++; $display("FAIL wrap_bresp got %b id=%0d want %b/7", resp, id, exp_resp);
    end
    total++;
    if (wr_addr_q.size() != 4) begin
      bad++; $display("FAIL wrap_count got %0d want 4", wr_addr_q.size());
    end
    while (wr_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      a = wr_addr_q.pop_front(); we = wr_we_q.pop_front();
      total++;
      if (a !== exp_addr_q[0] || we !== 4'hF) begin
        bad++; $display("FAIL wrap_addr got %h we=%h want %h we=f", a, we, exp_addr_q[0]);
      end
      void'(exp_addr_q.pop_front());
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] e;
    apply_reset();
    mem[16'h50] = 32'h11223344;
    wr_addr_q.delete(); wr_we_q.delete();
    exp_q.push_back(32'h11223344);
    @(negedge aclk);
    ifc.arid = 4'd1; ifc.araddr = 32'h140; ifc.arlen = 8'd0; ifc.arsize = 3'd2; ifc.arburst = 2'b01;
    ifc.awid = 4'd2; ifc.awaddr = 32'h140; ifc.awlen = 8'd0; ifc.awsize = 3'd2; ifc.awburst = 2'b01;
    ifc.arvalid = 1'b1; ifc.awvalid = 1'b1;
    #1;
    total++;
    if (ifc.arready !== 1'b1 || ifc.awready !== 1'b0) begin
      bad++; $display("FAIL arb_first got ar=%b aw=%b want 1/0", ifc.arready, ifc.awready);
    end
    @(posedge aclk); #1;
    ifc.arvalid = 1'b0;
    @(negedge aclk);
    ifc.rready = 1'b1;
    #1;
    e = exp_q.pop_front();
    total++;
    if (ifc.rvalid !== 1'b1 || ifc.rdata !== e || ifc.awready !== 1'b0) begin
      bad++; $display("FAIL arb_read got rv=%b %h aw=%b want 1 %h 0", ifc.rvalid, ifc.rdata, ifc.awready, e);
    end
    @(posedge aclk); #1;
    ifc.rready = 1'b0;
    @(negedge aclk);
    ifc.arvalid = 1'b1;
    #1;
    total++;
    if (ifc.awready !== 1'b1 || ifc.arready !== 1'b0) begin
      bad++; $display("FAIL arb_second got aw=%b ar=%b want 1/0", ifc.awready, ifc.arready);
    end
    @(posedge aclk); #1;
    ifc.awvalid = 1'b0;
    @(negedge aclk);
    ifc.wdata = 32'hAABBCCDD; ifc.wstrb = 4'b0011; ifc.wlast = 1'b1; ifc.wvalid = 1'b1;
    #1;
    total++;
    if (ifc.wready !== 1'b1 || ifc.arready !== 1'b0) begin
      bad++; $display("FAIL arb_wready got wr=%b ar=%b want 1/0", ifc.wready, ifc.arready);
    end
    @(posedge aclk); #1;
    ifc.wvalid = 1'b0;
    @(negedge aclk);
    ifc.bready = 1'b1;
    #1;
    total++;
    if (ifc.bvalid !== 1'b1 || ifc.bresp !== 2'b00 || ifc.bid !== 4'd2) begin
      bad++; $display("FAIL arb_bresp got bv=%b %b id=%0d want 1 00 2", ifc.bvalid, ifc.bresp, ifc.bid);
    end
    @(posedge aclk); #1;
    ifc.bready = 1'b0;
    exp_q.push_back(32'h1122CCDD);
    @(negedge aclk); #1;
    total++;
    if (ifc.arready !== 1'b1) begin
      bad++; $display("FAIL arb_third got ar=%b want 1", ifc.arready);
    end
    @(posedge aclk); #1;
    ifc.arvalid = 1'b0;
    @(negedge aclk);
    ifc.rready = 1'b1;
    #1;
    e = exp_q.pop_front();
    total++;
    if (ifc.rvalid !== 1'b1 || ifc.rdata !== e) begin
      bad++; $display("FAIL arb_strb_read got rv=%b %h want 1 %h", ifc.rvalid, ifc.rdata, e);
    end
    @(posedge aclk); #1;
    ifc.rready = 1'b0;
    total++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 16'h50 || wr_we_q[0] !== 4'b0011) begin
      bad++; $display("FAIL arb_strb_sram got n=%0d want one write at 0050 we=3", wr_addr_q.size());
    end
  endtask

  task automatic test_early_wlast();
    logic [1:0] resp; logic [3:0] id; logic [15:0] a;
    wr_addr_q.delete(); wr_we_q.delete(); exp_addr_q.delete();
    send_aw(4'd6, 32'h300, 8'd2, 2'b01);
    exp_addr_q.push_back(16'hC0); send_w(32'h111, 4'hF, 1'b0);
    exp_addr_q.push_back(16'hC1); send_w(32'h222, 4'hF, 1'b1);
    exp_addr_q.push_back(16'hC2); send_w(32'h333, 4'hF, 1'b0);
    @(negedge aclk); #1;
    total++;
    if (ifc.wready !== 1'b0 || ifc.bvalid !== 1'b1) begin
      bad++; $display("FAIL wlast_end got wready=%b bvalid=%b want 0/1", ifc.wready, ifc.bvalid);
    end
    recv_b(resp, id);
    total++;
    if (resp !== 2'b10 || id !== 4'd6) begin
      bad++; $display("FAIL wlast_bresp got %b id=%0d want 10/6", resp, id);
    end
    total++;
    if (wr_addr_q.size() != 3 || mem[16'hC2] !== 32'h333) begin
      bad++; $display("FAIL wlast_count got n=%0d last=%h want 3 333", wr_addr_q.size(), mem[16'hC2]);
    end
    while (wr_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      a = wr_addr_q.pop_front(); void'(wr_we_q.pop_front());
      total++;
      if (a !== exp_addr_q[0]) begin
        bad++; $display("FAIL wlast_addr got %h want %h", a, exp_addr_q[0]);
      end
      void'(exp_addr_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] data, e; logic last; logic [1:0] resp; logic [3:0] id;
    for (int i = 0; i < 8; i++) begin
      mem[16'h100 + i] = 32'h50 + 32'(i);
      exp_q.push_back(32'h50 + 32'(i));
    end
    send_ar(4'd5, 32'h400, 8'd7, 2'b01);
    for (int i = 0; i < 2; i++) begin
      recv_r(data, last, resp, id);
      e = exp_q.pop_front();
      total++;
      if (data !== e || last !== 1'b0 || id !== 4'd5) begin
        bad++; $display("FAIL midrst_beat %0d got %h last=%b id=%0d want %h 0 5", i, data, last, id, e);
      end
    end
    @(negedge aclk);
    ifc.rready = 1'b1;
    #1;
    total++;
    if (ifc.rvalid !== 1'b1 || ifc.rdata !== exp_q[0]) begin
      bad++; $display("FAIL midrst_beat2 got rv=%b %h want 1 %h", ifc.rvalid, ifc.rdata, exp_q[0]);
    end
    aresetn = 1'b0;
    #1;
    total++;
    if (ifc.rvalid !== 1'b0 || sram_en !== 1'b0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL midrst_drop got rv=%b en=%b st=%0d want 0/0/0", ifc.rvalid, sram_en, dbg_state);
    end
    // The abandoned beats will never be delivered.
    exp_q.delete();
    ifc.rready = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    exp_q.push_back(mem[16'h40]);
    @(negedge aclk);
    ifc.arid = 4'd4; ifc.araddr = 32'h100; ifc.arlen = 8'd0; ifc.arsize = 3'd2; ifc.arburst = 2'b01;
    ifc.arvalid = 1'b1;
    #1;
    total++;
    if (ifc.arready !== 1'b1 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL midrst_ar got ar=%b st=%0d want 1/0", ifc.arready, dbg_state);
    end
    @(posedge aclk); #1;
    ifc.arvalid = 1'b0;
    recv_r(data, last, resp, id);
    e = exp_q.pop_front();
    total++;
    if (data !== e || last !== 1'b1 || id !== 4'd4) begin
      bad++; $display("FAIL midrst_read got %h last=%b id=%0d want %h 1 4", data, last, id, e);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i) ^ 32'h5A5A0000;
    sram_rdata  = 32'd0;
    aresetn     = 1'b0;
    ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0; ifc.arburst = '0; ifc.arvalid = 1'b0;
    ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0; ifc.awvalid = 1'b0;
    ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0;
    ifc.rready = 1'b0; ifc.bready = 1'b0;

    test_reset();
    test_single();
    test_incr_backpressure();
    test_wrap();
    test_arbitration();
    test_early_wlast();
    test_reset_mid_burst();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
